// File: rtl/rx_pkg.sv
// Shared types for the USB RX bit decoder: FSM states, line states, default sync byte.
package rx_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_RECEIVE,
      ST_EOP,
      ST_ERROR
   } rx_state_t;

   // Encoding matches {d_plus, d_minus} so a line sample casts straight in.
   typedef enum logic [1:0] {
      LINE_SE0 = 2'b00,
      LINE_K   = 2'b01,
      LINE_J   = 2'b10,
      LINE_SE1 = 2'b11
   } line_t;

endpackage

// File: rtl/rx_nrzi_unstuff.sv
// Line classifier, NRZI decoder and ones counter feeding the RX bit decoder FSM.
// RX_STUFF_ERR_EN: flag a stuff bit that decodes as 1 instead of silently dropping it.
module rx_nrzi_unstuff
   import rx_pkg::*;
(
   input  logic  clk,
   input  logic  n_rst,
   input  logic  i_d_plus,
   input  logic  i_d_minus,
   input  logic  i_en_sample,
   input  logic  i_count_en,
   output line_t o_line_c,
   output logic  o_bit_c,
   output logic  o_keep_c,
   output logic  o_stuff_err_c
);

   localparam int unsigned ONES_W = 3;

   line_t             r_prev;
   logic [ONES_W-1:0] r_ones;
   logic              w_jk;
   logic              w_stuff;

   assign o_line_c = line_t'({i_d_plus, i_d_minus});
   assign w_jk     = (o_line_c == LINE_J) || (o_line_c == LINE_K);
   assign o_bit_c  = (o_line_c == r_prev);
   // Only J/K samples in SYNC/RECEIVE can be stuff bits; SE0 wins over a pending stuff.
   assign w_stuff  = i_count_en && w_jk && (r_ones == ONES_W'(6));
   assign o_keep_c = w_jk && !w_stuff;
`ifdef RX_STUFF_ERR_EN
   assign o_stuff_err_c = w_stuff && o_bit_c;
`else
   assign o_stuff_err_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_prev <= LINE_J;
         r_ones <= '0;
      end else if (i_en_sample) begin
         if (w_jk) begin
            r_prev <= o_line_c;
         end
         if (!i_count_en || w_stuff || !o_bit_c) begin
            r_ones <= '0;
         end else if (w_jk) begin
            r_ones <= r_ones + ONES_W'(1);
         end
      end
   end

endmodule

// File: rtl/rx_bit_decoder.sv
// USB RX bit decoder: sync detect, LSB-first byte assembly, EOP and error tracking.
// RX_STUFF_ERR_EN: a stuff bit decoding as 1 sends the packet to ERROR.
module rx_bit_decoder
   import rx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_plus,
   input  logic       d_minus,
   input  logic       en_sample,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       eop,
   output logic       rx_error
);

   localparam int unsigned CNT_W = 3;

   rx_state_t        r_state;
   logic [6:0]       r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic             r_se0_seen;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_eop;
   logic             r_rx_error;

   line_t            w_line;
   logic             w_bit;
   logic             w_keep;
   logic             w_stuff_err;
   logic             w_count_en;
   logic [7:0]       w_byte;

   assign w_count_en = (r_state == ST_SYNC) || (r_state == ST_RECEIVE);
   assign w_byte     = {w_bit, r_shift};

   rx_nrzi_unstuff u_nrzi (
      .clk           (clk),
      .n_rst         (n_rst),
      .i_d_plus      (d_plus),
      .i_d_minus     (d_minus),
      .i_en_sample   (en_sample),
      .i_count_en    (w_count_en),
      .o_line_c      (w_line),
      .o_bit_c       (w_bit),
      .o_keep_c      (w_keep),
      .o_stuff_err_c (w_stuff_err)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_se0_seen <= 1'b0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_eop      <= 1'b0;
         r_rx_error <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_eop      <= 1'b0;
         if (en_sample) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_line == LINE_K) begin
                     r_state    <= ST_SYNC;
                     r_shift    <= w_byte[7:1];
                     r_cnt      <= CNT_W'(1);
                     r_rx_error <= 1'b0;
                  end
               end
               ST_SYNC, ST_RECEIVE: begin
                  if (w_line == LINE_SE1 || w_stuff_err ||
                      (w_line == LINE_SE0 && r_state == ST_SYNC)) begin
                     r_state    <= ST_ERROR;
                     r_se0_seen <= 1'b0;
                     r_rx_error <= 1'b1;
                  end else if (w_line == LINE_SE0) begin
                     r_state <= ST_EOP;
                     if (r_cnt != '0) begin
                        r_rx_error <= 1'b1;
                     end
                  end else if (w_keep) begin
                     r_shift <= w_byte[7:1];
                     r_cnt   <= r_cnt + CNT_W'(1);
                     // Eighth bit closes the byte: sync check or data delivery.
                     if (r_cnt == CNT_W'(7)) begin
                        if (r_state == ST_RECEIVE) begin
                           r_rx_data  <= w_byte;
                           r_rx_valid <= 1'b1;
                        end else if (w_byte == SYNC_BYTE) begin
                           r_state <= ST_RECEIVE;
                        end else begin
                           r_state    <= ST_ERROR;
                           r_se0_seen <= 1'b0;
                           r_rx_error <= 1'b1;
                        end
                     end
                  end
               end
               ST_EOP: begin
                  if (w_line == LINE_J) begin
                     r_state <= ST_IDLE;
                     r_eop   <= 1'b1;
                  end else if (w_line != LINE_SE0) begin
                     r_state    <= ST_ERROR;
                     r_se0_seen <= 1'b0;
                     r_rx_error <= 1'b1;
                  end
               end
               ST_ERROR: begin
                  if (w_line == LINE_SE0) begin
                     r_se0_seen <= 1'b1;
                  end else if (w_line == LINE_J && r_se0_seen) begin
                     r_state    <= ST_IDLE;
                     r_se0_seen <= 1'b0;
                  end else begin
                     r_se0_seen <= 1'b0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign eop      = r_eop;
   assign rx_error = r_rx_error;

endmodule
